fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single `PC` register and increment/branch/jump logic in the processor top. It owns the program counter and issues sequential addresses to the synchronous instruction memory, which has a 1-cycle read latency. Returned words are buffered in a small prefetch FIFO and handed to decode over a valid/ready handshake. A taken branch or jump arrives as a redirect that flushes all buffered and in-flight words.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers responses in a FWFT prefetch FIFO. Define FETCH_BYPASS_EN for same-cycle bypass.
module fetch_unit #(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     INSTR_W  = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_q,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       inst_valid,
  output logic [INSTR_W-1:0]         inst,
  output logic [PC_W-1:0]            inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [PC_W-1:0]    r_pc;
  logic               r_inflight;
  logic [PC_W-1:0]    r_rsp_pc;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [OCC_W-1:0]   w_occ;
  logic               w_credit;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Credit counts buffered words plus the one in flight; both are registered.
  assign w_occ     = {1'b0, r_count} + OCC_W'(r_inflight);
  assign w_credit  = w_occ < OCC_W'(DEPTH);
  assign imem_req  = reset && !redirect && w_credit;
  assign imem_addr = r_pc;
  assign count     = r_count;
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && inst_ready;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;

  assign w_bypass   = r_inflight && w_empty;
  assign inst_valid = !w_empty || w_bypass;
  assign inst       = w_bypass ? imem_q   : r_instr_mem[r_rd_ptr];
  assign inst_pc    = w_bypass ? r_rsp_pc : r_pc_mem[r_rd_ptr];
  // A bypassed word taken by decode never enters the FIFO.
  assign w_push     = r_inflight && !redirect && !(w_bypass && inst_ready);
`else
  assign inst_valid = !w_empty;
  assign inst       = r_instr_mem[r_rd_ptr];
  assign inst_pc    = r_pc_mem[r_rd_ptr];
  assign w_push     = r_inflight && !redirect;
`endif

  // PC, in-flight tracking; redirect kills the response due next cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_rsp_pc   <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_pc     <= r_pc + PC_W'(1);
        r_rsp_pc <= r_pc;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, cleared on reset so idle outputs read zero.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
      end
    end else if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_q;
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table for the post-reset ramp,
// scoreboard of expected PCs checked on every accepted instruction.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [15:0] imem_q = '0;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [11:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  count;

  fetch_unit #(.PC_W(12), .INSTR_W(16), .DEPTH(4), .RESET_PC(12'h000)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return 16'h1000 + 16'(a);
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) imem_q <= mem_word(imem_addr);

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [11:0] exp_addr;
    logic        exp_valid;
    logic [11:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t        vecs [6];
  logic [11:0] sbq [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected PC.
  task automatic step_neg();
    logic [11:0] e;
    @(negedge clk);
    if (inst_valid && inst_ready) begin
      pops++;
      if (sbq.size() == 0) begin
        chk("extra_pop", 32'(inst_pc), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_inst_pc", 32'(inst_pc), 32'(e));
        chk("sb_inst", 32'(inst), 32'(mem_word(e)));
      end
    end
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() == 0) inst_ready = 1'b0;
  endtask

  task automatic tick();
    step_neg();
    step_pos();
  endtask

  initial begin
    bit found, trig, seen0, seen_r;
    int r_cyc, p0;

    for (int c = 0; c < 6; c++) begin
      vecs[c].ready     = 1'b1;
      vecs[c].exp_req   = 1'b1;
      vecs[c].exp_addr  = 12'(c);
      vecs[c].exp_valid = (c >= LAT);
      vecs[c].exp_pc    = (c >= LAT) ? 12'(c - LAT) : 12'h000;
      vecs[c].exp_count = (!BYP && c >= 2) ? 3'd1 : 3'd0;
    end

    reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h000);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);

    // Reset release and free-run ramp.
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) sbq.push_back(12'(i));
    for (int c = 0; c < 6; c++) begin
      inst_ready = vecs[c].ready;
      step_neg();
      chk($sformatf("vec%0d_req", c), 32'(imem_req), 32'(vecs[c].exp_req));
      chk($sformatf("vec%0d_addr", c), 32'(imem_addr), 32'(vecs[c].exp_addr));
      chk($sformatf("vec%0d_valid", c), 32'(inst_valid), 32'(vecs[c].exp_valid));
      chk($sformatf("vec%0d_count", c), 32'(count), 32'(vecs[c].exp_count));
      if (vecs[c].exp_valid)
        chk($sformatf("vec%0d_pc", c), 32'(inst_pc), 32'(vecs[c].exp_pc));
      step_pos();
    end
    p0 = pops;
    repeat (20) tick();
    chk("free_run_no_gaps", 32'(pops - p0), 32'd20);

    // Backpressure: FIFO saturates, issue stops, head word holds.
    inst_ready = 1'b0;
    repeat (10) tick();
    step_neg();
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_head_pc", 32'(inst_pc), 32'(sbq[0]));
    step_pos();
    inst_ready = 1'b1;
    repeat (6) tick();

    // Asynchronous reset with three words buffered.
    inst_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step_neg();
      if (count == 3'd3) found = 1'b1;
      else step_pos();
    end
    chk("arst_reached_count3", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'h000);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) sbq.push_back(12'(i));
    inst_ready = 1'b1;

    // Redirect to 0x080 in the cycle PC 3 is popped.
    trig = 1'b0; seen0 = 1'b0; seen_r = 1'b0; r_cyc = 0;
    for (int k = 0; k < 16; k++) begin
      redirect = 1'b0;
      if (!trig && inst_valid && inst_pc == 12'h003) begin
        redirect = 1'b1;
        redirect_pc = 12'h080;
        r_cyc = cyc;
        trig = 1'b1;
        sbq.push_back(12'h080); sbq.push_back(12'h081); sbq.push_back(12'h082);
      end
      step_neg();
      if (!seen0 && inst_valid) begin
        chk("resume_lat", 32'(cyc), 32'(LAT));
        chk("resume_pc", 32'(inst_pc), 32'h000);
        seen0 = 1'b1;
      end
      if (trig && cyc > r_cyc && !seen_r && inst_valid) begin
        chk("redir_lat", 32'(cyc - r_cyc), 32'(LAT + 1));
        chk("redir_pc", 32'(inst_pc), 32'h080);
        seen_r = 1'b1;
      end
      step_pos();
    end
    redirect = 1'b0;
    chk("redir_triggered", 32'(trig), 32'd1);
    chk("redir_target_seen", 32'(seen_r), 32'd1);
    chk("redir_drained", 32'(sbq.size()), 32'd0);

    // PC wrap-around through a redirect to 0xFFE.
    inst_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 12'hFFE;
    sbq.push_back(12'hFFE); sbq.push_back(12'hFFF);
    sbq.push_back(12'h000); sbq.push_back(12'h001);
    tick();
    redirect = 1'b0;
    inst_ready = 1'b1;
    repeat (10) tick();
    chk("wrap_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
